cbus_nway_arbiter: RTL

- N-channel CBus arbiter; successor to the fixed 2-input instruction/data mux at the top level.
- Takes NUM_CH upstream CBus requesters (ICache, DBus converter, future DMA/PTW) and drives a single downstream CBus.
- Holds each grant for a whole burst.
- Arbitration policy is selectable by parameter: fixed priority or round-robin.

---
 rtl/cbus_nway_arbiter_pkg.sv | 26 ++
 rtl/cbus_nway_arbiter_if.sv | 15 +
 rtl/cbus_nway_arbiter_rr_picker.sv | 23 ++
 rtl/cbus_nway_arbiter.sv | 80 ++++++++
 4 files changed

// File: rtl/cbus_nway_arbiter_pkg.sv
// cbus_nway_arbiter_pkg: CBus request/response types, arbiter policy/state enums and limits
package cbus_nway_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_policy_t;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;

    localparam int ARB_MAX_CH = 8;

endpackage

// File: rtl/cbus_nway_arbiter_if.sv
// cbus_nway_arbiter_if: upstream request/response array and the single downstream CBus; master = arbiter side, slave = requesters/downstream side
interface cbus_nway_arbiter_if #(
    parameter int NUM_CH = 2
);
    import cbus_nway_arbiter_pkg::*;

    cbus_req_t  [NUM_CH-1:0] ireqs;
    cbus_resp_t [NUM_CH-1:0] iresps;
    cbus_req_t               oreq;
    cbus_resp_t              oresp;

    modport master (input ireqs, oresp, output iresps, oreq);
    modport slave  (output ireqs, oresp, input iresps, oreq);

endinterface

// File: rtl/cbus_nway_arbiter_rr_picker.sv
// cbus_nway_arbiter_rr_picker: combinational cyclic priority pick starting at start_i (start_i=0 gives fixed priority)
module cbus_nway_arbiter_rr_picker #(
    parameter int NUM_CH = 2,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] valid_i,
    input  logic [SEL_W-1:0]  start_i,
    output logic [SEL_W-1:0]  win_o,
    output logic              any_o
);
    logic [NUM_CH-1:0] rot;
    int                off;

    // rotate start_i down to bit 0, take the lowest set bit, then map the offset back to a channel index
    always_comb begin
        rot = NUM_CH'({valid_i, valid_i} >> start_i);
        off = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) off = rot[i] ? i : off;
        win_o = SEL_W'((off + int'(start_i)) % NUM_CH);
        any_o = |valid_i;
    end

endmodule

// File: rtl/cbus_nway_arbiter.sv
// cbus_nway_arbiter: NUM_CH-to-1 CBus arbiter holding each grant for a whole burst; define CBUS_ARB_STATS_EN for per-channel completion counters
module cbus_nway_arbiter
    import cbus_nway_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int POLICY = 1,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    cbus_nway_arbiter_if.master     bus,
    output logic                    busy,
    output logic [SEL_W-1:0]        grant_idx,
    output logic [NUM_CH-1:0][31:0] grant_cnt
);
    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d, rr_ptr_q, rr_ptr_d, start, win;
    logic [NUM_CH-1:0] valid_vec;
    logic              any_valid, done;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_vld
        assign valid_vec[i] = bus.ireqs[i].valid;
    end

    assign start = (POLICY == int'(ARB_RR)) ? rr_ptr_q : '0;
    assign done  = (state_q == ARB_BUSY) && bus.oresp.ready && bus.oresp.last;

    cbus_nway_arbiter_rr_picker #(
        .NUM_CH(NUM_CH),
        .SEL_W (SEL_W)
    ) u_picker (
        .valid_i(valid_vec),
        .start_i(start),
        .win_o  (win),
        .any_o  (any_valid)
    );

    // state, selected channel and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // grant on any request while idle; release after the last accepted beat and advance the pointer past the owner
    always_comb begin
        state_d  = (state_q == ARB_IDLE) ? (any_valid ? ARB_BUSY : ARB_IDLE) : (done ? ARB_IDLE : ARB_BUSY);
        sel_d    = (state_q == ARB_IDLE && any_valid) ? win : sel_q;
        rr_ptr_d = done ? ((int'(sel_q) == NUM_CH - 1) ? '0 : sel_q + SEL_W'(1)) : rr_ptr_q;
    end

    // route the owner's request downstream and the downstream response only to the owner
    always_comb begin
        busy      = state_q == ARB_BUSY;
        grant_idx = sel_q;
        bus.oreq  = busy ? bus.ireqs[sel_q] : '0;
        for (int i = 0; i < NUM_CH; i++) bus.iresps[i] = (busy && int'(sel_q) == i) ? bus.oresp : '0;
    end

`ifdef CBUS_ARB_STATS_EN
    logic [NUM_CH-1:0][31:0] cnt_q;

    // count completed transactions per channel, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else if (done) cnt_q[sel_q] <= cnt_q[sel_q] + 32'd1;
    end

    assign grant_cnt = cnt_q;
`else
    assign grant_cnt = '0;
`endif

endmodule
